// File: rtl/act_pipe.sv
// act_pipe: multi-lane activation stage between the MAC accumulators and the
// next layer's input buffer. Each lane takes a double-width signed accumulation
// (2F fractional bits), applies ReLU / leaky ReLU / identity / clipped ReLU,
// and saturates to single-width fixed point (F fractional bits). The beat moves
// through a 2-stage valid/ready pipeline. Saturated lanes are flagged per beat
// and counted.
//
// Optional build macro:
//   ACT_ROUND_EN  defined   -> round half-up before slicing
//                 undefined -> plain truncation
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-high reset
//   in_valid   in   input beat valid
//   in_ready   out  input beat accepted when in_valid & in_ready
//   in_mode    in   00 ReLU, 01 leaky ReLU, 10 identity, 11 clipped ReLU
//   in_data    in   LANES x 2W signed, lane k at [k*2W +: 2W]
//   out_valid  out  output beat valid
//   out_ready  in   downstream accept
//   out_data   out  LANES x W signed, lane k at [k*W +: W]
//   out_sat    out  per-lane saturation flag for the current output beat
//   sat_count  out  running count of saturated lanes (sticks at all-ones)
//   sat_clr    in   synchronous clear of sat_count, wins over increment
module act_pipe #(
    parameter int unsigned           dataWidth  = 16,
    parameter int unsigned           intWidth   = 4,
    parameter int unsigned           LANES      = 4,
    parameter int unsigned           LEAK_SHIFT = 3,
    parameter logic [dataWidth-1:0]  CLIP_MAX   = 16'h6000,
    parameter int unsigned           CNT_WIDTH  = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [1:0]                   in_mode,
    input  logic [LANES*2*dataWidth-1:0] in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [LANES*dataWidth-1:0]   out_data,
    output logic [LANES-1:0]             out_sat,
    output logic [CNT_WIDTH-1:0]         sat_count,
    input  logic                         sat_clr
);

    localparam int unsigned W   = dataWidth;
    localparam int unsigned I   = intWidth;
    localparam int unsigned F   = W - I;
    localparam int unsigned XW  = 2 * W;
    // One guard bit above the input width so rounding can never wrap.
    localparam int unsigned VW  = XW + 1;
    localparam int unsigned PW  = $clog2(LANES + 1);
    localparam int unsigned CW1 = CNT_WIDTH + 1;

    typedef enum logic [1:0] {
        ModeRelu  = 2'b00,
        ModeLeaky = 2'b01,
        ModeIdent = 2'b10,
        ModeClip  = 2'b11
    } mode_e;

    // Activation, conversion and saturation for one lane; returns {sat, result}.
    function automatic logic [W:0] lane_act(input logic [1:0] mode,
                                            input logic signed [XW-1:0] x);
        logic signed [XW-1:0] v;
        logic [VW-1:0]        vr;
        logic [I+1:0]         top;
        logic [W-1:0]         r;
        logic                 sat;
        case (mode)
            ModeRelu, ModeClip: v = x[XW-1] ? '0 : x;
            ModeLeaky:          v = x[XW-1] ? (x >>> LEAK_SHIFT) : x;
            default:            v = x;
        endcase
        vr = {v[XW-1], v};
`ifdef ACT_ROUND_EN
        vr = vr + (VW'(1) << (F - 1));
`endif
        // Guard bit plus the I+1 bits that must all agree for the slice to fit.
        top = vr[VW-1 -: I+2];
        sat = ~((&top) | ~(|top));
        if (sat) begin
            r = vr[VW-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        end else begin
            r = vr[XW-1-I -: W];
        end
        if ((mode == ModeClip) && ($signed(r) > $signed(CLIP_MAX))) begin
            r   = CLIP_MAX;
            sat = 1'b1;
        end
        return {sat, r};
    endfunction

    // Stage 1: raw beat and its mode.
    logic                         s1_valid;
    logic [LANES*2*W-1:0]         s1_data;
    logic [1:0]                   s1_mode;
    // Stage 2: converted result and flags, driven straight to the outputs.
    logic                         s2_valid;
    logic [LANES*W-1:0]           s2_data;
    logic [LANES-1:0]             s2_sat;

    logic                         s1_load;
    logic                         s2_load;
    logic                         out_hs;
    logic [LANES*W-1:0]           res_data;
    logic [LANES-1:0]             res_sat;
    logic [PW-1:0]                sat_pop;
    logic [CW1-1:0]               cnt_sum;
    logic [CNT_WIDTH-1:0]         cnt_d;

    assign s2_load   = s1_valid & (~s2_valid | out_ready);
    assign in_ready  = ~s1_valid | s2_load;
    assign s1_load   = in_valid & in_ready;
    assign out_hs    = s2_valid & out_ready;

    assign out_valid = s2_valid;
    assign out_data  = s2_data;
    assign out_sat   = s2_sat;

    always_comb begin
        res_data = '0;
        res_sat  = '0;
        for (int k = 0; k < LANES; k++) begin
            logic [W:0] lane_res;
            lane_res = lane_act(s1_mode, s1_data[k*XW +: XW]);
            res_data[k*W +: W] = lane_res[W-1:0];
            res_sat[k]         = lane_res[W];
        end
    end

    always_comb begin
        sat_pop = '0;
        for (int k = 0; k < LANES; k++) begin
            sat_pop = sat_pop + PW'(s2_sat[k]);
        end
        cnt_sum = {1'b0, sat_count} + CW1'(sat_pop);
        cnt_d   = sat_count;
        if (sat_clr) begin
            cnt_d = '0;
        end else if (out_hs) begin
            // Carry out of the counter width means it would wrap: pin at all-ones.
            cnt_d = cnt_sum[CNT_WIDTH] ? '1 : cnt_sum[CNT_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_mode  <= '0;
        end else begin
            if (s1_load) begin
                s1_valid <= 1'b1;
                s1_data  <= in_data;
                s1_mode  <= in_mode;
            end else if (s2_load) begin
                s1_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_data  <= '0;
            s2_sat   <= '0;
        end else begin
            if (s2_load) begin
                s2_valid <= 1'b1;
                s2_data  <= res_data;
                s2_sat   <= res_sat;
            end else if (out_ready) begin
                s2_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sat_count <= '0;
        end else begin
            sat_count <= cnt_d;
        end
    end

endmodule

// File: tb/tb_act_pipe.sv
// Bench for act_pipe: directed beats with known results, a stalled stream of
// random beats checked against a lane model through a scoreboard, sat_clr
// priority, mid-stream reset and the rounding option.
module tb_act_pipe;

    localparam int unsigned W     = 16;
    localparam int unsigned I     = 4;
    localparam int unsigned F     = W - I;
    localparam int unsigned LANES = 4;
    localparam int unsigned LEAK  = 3;
    localparam int unsigned CW    = 4;
    localparam longint      CLIP  = 24576;  // 16'h6000
    localparam int          CMAX  = 15;     // all-ones of a 4-bit counter

    logic                     clk;
    logic                     rst;
    logic                     in_valid;
    logic                     in_ready;
    logic [1:0]               in_mode;
    logic [LANES*2*W-1:0]     in_data;
    logic                     out_valid;
    logic                     out_ready;
    logic [LANES*W-1:0]       out_data;
    logic [LANES-1:0]         out_sat;
    logic [CW-1:0]            sat_count;
    logic                     sat_clr;

    int checks = 0;
    int errors = 0;

    act_pipe #(
        .dataWidth  (W),
        .intWidth   (I),
        .LANES      (LANES),
        .LEAK_SHIFT (LEAK),
        .CLIP_MAX   (16'h6000),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mode   (in_mode),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sat   (out_sat),
        .sat_count (sat_count),
        .sat_clr   (sat_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [67:0] obs, input logic [67:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference lane model in integer arithmetic: returns {sat[3:0], data[63:0]}.
    function automatic logic [67:0] model(input logic [1:0] mode, input logic [127:0] d);
        logic [63:0] od;
        logic [3:0]  os;
        longint      x;
        longint      v;
        longint      q;
        od = '0;
        os = '0;
        for (int k = 0; k < LANES; k++) begin
            x = $signed(d[k*32 +: 32]);
            case (mode)
                2'd1:    v = (x < 0) ? (x >>> LEAK) : x;
                2'd2:    v = x;
                default: v = (x < 0) ? 0 : x;
            endcase
`ifdef ACT_ROUND_EN
            v = v + (longint'(1) << (F - 1));
`endif
            q = v >>> F;
            if (q > 32767) begin
                q = 32767;
                os[k] = 1'b1;
            end else if (q < -32768) begin
                q = -32768;
                os[k] = 1'b1;
            end
            if (mode == 2'd3 && q > CLIP) begin
                q = CLIP;
                os[k] = 1'b1;
            end
            od[k*16 +: 16] = q[15:0];
        end
        return {os, od};
    endfunction

    // Scoreboard / monitor, sampled on the falling edge.
    logic [67:0] exp_q[$];
    int          stamp_q[$];
    int          cyc = 0;
    int          last_stall = -100;
    int          exp_cnt = 0;
    bit          prev_stall = 1'b0;
    logic [67:0] prev_out;

    always @(negedge clk) begin
        logic [67:0] e;
        int          k;
        int          pop;
        cyc++;
        if (rst) begin
            exp_q.delete();
            stamp_q.delete();
            exp_cnt    = 0;
            prev_stall = 1'b0;
        end else begin
            chk("sat_count", 68'(sat_count), 68'(exp_cnt));
            if (prev_stall) begin
                chk("hold_valid", 68'(out_valid), 68'(1));
                chk("hold_data", {out_sat, out_data}, prev_out);
            end else if (out_valid) begin
                if (stamp_q.size() == 0) begin
                    chk("unexpected_out", 68'(out_valid), 68'(0));
                end else begin
                    k = stamp_q.pop_front();
                    if (last_stall < k + 1) chk("latency", 68'(cyc - k), 68'(2));
                    else chk("latency_stalled", 68'(cyc - k > 2), 68'(1));
                end
            end
            pop = 0;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_hs", 68'(out_valid), 68'(0));
                end else begin
                    e = exp_q.pop_front();
                    chk("out_beat", {out_sat, out_data}, e);
                    pop = $countones(e[67:64]);
                end
            end
            if (sat_clr) exp_cnt = 0;
            else exp_cnt = (exp_cnt + pop > CMAX) ? CMAX : exp_cnt + pop;
            if (in_valid && in_ready) begin
                exp_q.push_back(model(in_mode, in_data));
                stamp_q.push_back(cyc);
            end
            if (out_valid && !out_ready) begin
                last_stall = cyc;
                prev_stall = 1'b1;
                prev_out   = {out_sat, out_data};
            end else begin
                prev_stall = 1'b0;
            end
        end
    end

    // Single beat into an empty pipeline, compared against hand-derived values.
    task automatic beat(input string tag, input logic [1:0] mode, input logic [127:0] d,
                        input logic [63:0] exp_d, input logic [3:0] exp_s);
        bit got;
        in_mode   = mode;
        in_data   = d;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            if (out_valid) got = 1'b1;
        end
        chk({tag, "_valid"}, 68'(out_valid), 68'(1));
        chk(tag, {out_sat, out_data}, {exp_s, exp_d});
        @(posedge clk);
        #1;
    endtask

    logic [127:0] s_data[10];
    logic [1:0]   s_mode[10];

    initial begin
        int  idx;
        int  t;
        bit  acc;
        rst      = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        sat_clr  = 1'b0;
        in_mode  = 2'd0;
        in_data  = '0;
        for (int i = 0; i < 10; i++) begin
            s_data[i] = {$urandom, $urandom, $urandom, $urandom};
            s_mode[i] = 2'($urandom_range(0, 3));
        end

        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 68'(out_valid), 68'(0));
        chk("rst_sat_count", 68'(sat_count), 68'(0));
        chk("rst_out_data", 68'(out_data), 68'(0));
        chk("rst_out_sat", 68'(out_sat), 68'(0));
        rst = 1'b0;
        #1 chk("in_ready_after_rst", 68'(in_ready), 68'(1));

        // Directed values.
        beat("relu_pos_neg", 2'd0, {64'h0, 32'hFF000000, 32'h01000000},
             64'h0000_0000_0000_1000, 4'b0000);
        beat("relu_pos_ovf", 2'd0, {96'h0, 32'h08000000}, 64'h0000_0000_0000_7FFF, 4'b0001);
        chk("cnt_after_first_sat", 68'(sat_count), 68'(1));
        beat("ident_neg_ovf", 2'd2, {96'h0, 32'hF0000000}, 64'h0000_0000_0000_8000, 4'b0001);
        beat("leaky_neg", 2'd1, {96'h0, 32'hFF000000}, 64'h0000_0000_0000_FE00, 4'b0000);
        beat("clip", 2'd3, {64'h0, 32'h05000000, 32'h07000000},
             64'h0000_0000_5000_6000, 4'b0001);
        chk("cnt_after_clip", 68'(sat_count), 68'(3));

        // Stream of 10 beats with a 5-cycle output stall.
        idx = 0;
        t   = 0;
        while (idx < 10 && t < 60) begin
            in_valid  = 1'b1;
            in_mode   = s_mode[idx];
            in_data   = s_data[idx];
            out_ready = !(t >= 4 && t < 9);
            @(negedge clk);
            if (t == 8) chk("stall_in_ready", 68'(in_ready), 68'(0));
            acc = in_ready;
            @(posedge clk);
            #1;
            if (acc) idx++;
            t++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("stream_accepted", 68'(idx), 68'(10));
        repeat (5) @(posedge clk);
        #1 chk("stream_drained", 68'(exp_q.size()), 68'(0));

        // Reset with two beats in flight.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_mode   = 2'd2;
        in_data   = {96'h0, 32'h08000000};
        @(posedge clk);
        #1 in_data = {96'h0, 32'hF0000000};
        @(posedge clk);
        #1 in_valid = 1'b0;
        chk("pre_rst_valid", 68'(out_valid), 68'(1));
        chk("pre_rst_full", 68'(in_ready), 68'(0));
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", 68'(out_valid), 68'(0));
        chk("midrst_sat_count", 68'(sat_count), 68'(0));
        chk("midrst_out_data", 68'(out_data), 68'(0));
        @(posedge clk);
        #1 rst = 1'b0;
        out_ready = 1'b1;
        chk("post_rst_in_ready", 68'(in_ready), 68'(1));
        repeat (4) begin
            @(negedge clk);
            chk("post_rst_no_output", 68'(out_valid), 68'(0));
        end
        @(posedge clk);
        #1;

        // sat_clr in the same cycle as a saturating handshake.
        beat("pre_clr_sat", 2'd0, {96'h0, 32'h08000000}, 64'h0000_0000_0000_7FFF, 4'b0001);
        chk("cnt_before_clr", 68'(sat_count), 68'(1));
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_mode   = 2'd0;
        in_data   = {96'h0, 32'h08000000};
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(posedge clk);
        #1 chk("clr_beat_waiting", 68'({out_valid, out_sat}), 68'(5'b10001));
        sat_clr   = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1 sat_clr = 1'b0;
        chk("sat_clr_priority", 68'(sat_count), 68'(0));

        // Half-LSB input: rounds up only when rounding is built in.
`ifdef ACT_ROUND_EN
        beat("round_half", 2'd2, {96'h0, 32'h00000800}, 64'h0000_0000_0000_0001, 4'b0000);
`else
        beat("round_half", 2'd2, {96'h0, 32'h00000800}, 64'h0000_0000_0000_0000, 4'b0000);
`endif

        repeat (2) @(posedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/act_pipe.md
Name: act_pipe

Overview:
- Multi-lane, mode-selectable activation stage placed between the neuron MAC accumulators and the next layer's input buffer.
- Takes double-width fixed-point accumulations and applies ReLU, leaky ReLU, signed identity or clipped ReLU.
- Saturates each result to single-width fixed point through a 2-stage valid/ready pipeline.
- Counts saturation events for the quantisation-tuning flow.

Parameters:
- dataWidth, 16, output width W per lane; fractional bits F = W - I.
- intWidth, 4, output integer bits I including sign.
- LANES, 4, parallel lanes per beat.
- LEAK_SHIFT, 3, leaky-ReLU negative slope is 2^-LEAK_SHIFT (arithmetic right shift).
- CLIP_MAX, 16'h6000, upper clamp for clipped ReLU, in output format (6.0 at default).
- CNT_WIDTH, 16, saturation counter width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted when in_valid & in_ready.
- in_mode  in  2  00 ReLU, 01 leaky ReLU, 10 identity, 11 clipped ReLU; sampled with the beat.
- in_data  in  LANES*2*W  lane k at [k*2W +: 2W]; signed, 2F fractional bits.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accept.
- out_data  out  LANES*W  lane k at [k*W +: W]; signed, F fractional bits.
- out_sat  out  LANES  per-lane flag, 1 = that lane saturated in this beat.
- sat_count  out  CNT_WIDTH  running count of saturated lanes.
- sat_clr  in  1  synchronous clear of sat_count.

Behaviour:
- Reset: s1_valid, s2_valid, out_valid and sat_count go to 0; out_data and out_sat go to 0; in_ready goes to 1 once reset is released.
- Pipeline control:
  - s2_load = s1_valid & (~s2_valid | out_ready).
  - s1_load = in_valid & in_ready.
  - in_ready = ~s1_valid | s2_load (combinational).
  - out_valid = s2_valid.
  - Stage 1 holds in_data and in_mode. Stage 2 holds the result and the flags.
  - Output data, flags and valid stay stable while out_valid & ~out_ready.
- Latency: 2 cycles from acceptance to out_valid. With out_ready held high, throughput is 1 beat per cycle.
- Per-lane arithmetic on the 2W-bit signed value x:
  - mode 00: if x < 0, v = 0; otherwise v = x.
  - mode 01: if x < 0, v = x >>> LEAK_SHIFT; otherwise v = x.
  - mode 10: v = x.
  - mode 11: same as mode 00, then the clamp below.
- Conversion to output format:
  - Result is v[2W-1-I -: W].
  - Overflow when bits v[2W-1 -: I+1] are not all equal.
  - Positive overflow gives 16'h7FFF (generally {0,1...}). Negative overflow gives 16'h8000 (generally {1,0...}).
  - Mode 11 clamp: after conversion, any result > CLIP_MAX becomes CLIP_MAX, and the sat flag is set.
  - out_sat[k] = 1 whenever lane k was overflow-saturated or clamped.
- sat_count:
  - Increments by popcount(out_sat) when out_valid & out_ready.
  - Sticks at all-ones and does not wrap.
  - sat_clr has priority: in a cycle with sat_clr = 1 the counter becomes 0 and the concurrent increment is dropped.
- Boundary cases:
  - Pipeline full with out_ready = 0: in_ready = 0 and no beat is lost.
  - Simultaneous output handshake and new input: both proceed in the same cycle.
  - Reset asserted mid-stream: in-flight beats are discarded and no partial output appears.
  - Changing in_mode between beats: each beat is processed with its own sampled mode.

Optional Feature:
- Macro ACT_ROUND_EN.
- Defined: round half-up before slicing. Add 1 << (F-1) to v, computed at 2W+1 bits so the addition cannot wrap. Overflow check and clamp apply to the rounded value.
- Undefined: plain truncation, as above.
- Latency is unchanged either way.

Test Plan:
- W=16, I=4, mode 00, lane0 = 32'h01000000 (1.0) -> out 16'h1000, sat 0. Lane1 = 32'hFF000000 (-1.0) -> 16'h0000.
- Mode 00, lane0 = 32'h08000000 (8.0) -> 16'h7FFF, out_sat[0] = 1, sat_count +1 after handshake. Mode 10, lane0 = 32'hF0000000 (-16.0) -> 16'h8000, sat 1.
- Mode 01, lane0 = 32'hFF000000 -> 16'hFE00 (-0.125). Mode 11, lane0 = 32'h07000000 -> 16'h6000, sat 1. Lane1 = 32'h05000000 -> 16'h5000, sat 0.
- Stream 10 beats; hold out_ready = 0 for 5 cycles mid-stream.
  - in_ready drops after 2 beats are buffered.
  - Outputs stay stable while stalled.
  - All 10 beats emerge in order, none lost or duplicated; latency is 2 with no stall.
- sat_clr asserted in the same cycle as a saturating handshake -> sat_count = 0. Assert rst with 2 beats in flight -> out_valid = 0 immediately and sat_count = 0.
- Rounding, lane0 = 32'h00000800 (half LSB): with ACT_ROUND_EN -> 16'h0001; without -> 16'h0000.
